// File: rtl/frogger_pkg.sv
// Shared constants, state/direction types and lane wrap arithmetic for the Frogger game sequencer.
// Pure definitions: no latency, no backpressure.
package frogger_pkg;

  localparam int NUM_LANES   = 5;
  localparam int SCREEN_W    = 640;
  localparam int FROG_STEP   = 16;
  localparam int START_LIVES = 3;
  localparam int HIT_FRAMES  = 60;

  localparam logic [9:0] FROG_START_COL = 10'd320;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PLAY = 3'd1;
  localparam logic [2:0] ST_HIT  = 3'd2;
  localparam logic [2:0] ST_OVER = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PLAY = ST_PLAY,
    S_HIT  = ST_HIT,
    S_OVER = ST_OVER
  } game_state_e;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } lane_dir_e;

  localparam logic [2:0] LANE_SPEED [0:NUM_LANES-1] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd4};
  localparam lane_dir_e  LANE_DIR   [0:NUM_LANES-1] = '{DIR_R, DIR_L, DIR_R, DIR_L, DIR_R};

  // One wrap-around scroll step; the 11-bit sum keeps off+speed from overflowing before the wrap.
  function automatic logic [9:0] lane_step(input logic [9:0] off, input logic [2:0] speed,
                                           input lane_dir_e dir);
    logic [10:0] wide;
    logic [10:0] sp;
    sp = {8'd0, speed};
    if (dir == DIR_R) begin
      wide = {1'b0, off} + sp;
      if (wide >= 11'(SCREEN_W)) wide = wide - 11'(SCREEN_W);
    end else if ({1'b0, off} < sp) begin
      wide = {1'b0, off} + 11'(SCREEN_W) - sp;
    end else begin
      wide = {1'b0, off} - sp;
    end
    return wide[9:0];
  endfunction

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// Control/status bundle between the game sequencer (slave) and its environment (master).
// Plain wires: no latency, no backpressure (all inputs are single-cycle pulses or levels).
interface frogger_game_ctrl_if;
  import frogger_pkg::*;

  logic                     frame_tick;
  logic                     btn_start;
  logic                     btn_up;
  logic                     btn_down;
  logic                     btn_left;
  logic                     btn_right;
  logic                     collision;
  logic [NUM_LANES*10-1:0]  lane_off;
  logic [9:0]               frog_col;
  logic [2:0]               frog_row;
  logic [1:0]               lives;
  logic [7:0]               score;
  logic [2:0]               game_state;

  modport slave (
    input  frame_tick, btn_start, btn_up, btn_down, btn_left, btn_right, collision,
    output lane_off, frog_col, frog_row, lives, score, game_state
  );

  modport master (
    output frame_tick, btn_start, btn_up, btn_down, btn_left, btn_right, collision,
    input  lane_off, frog_col, frog_row, lives, score, game_state
  );

endinterface

// File: rtl/frogger_lane_mover.sv
// One car-lane scroll offset register; clr zeroes it, adv steps it by speed with wrap at SCREEN_W.
// Result visible the cycle after clr/adv; no backpressure.
module frogger_lane_mover
  import frogger_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  input  logic [2:0] speed,
  input  lane_dir_e  dir,
  output logic [9:0] off
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      off <= 10'd0;
    end else if (adv) begin
      off <= lane_step(off, speed, dir);
    end
  end

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: game FSM, frog position, lives/score, hit timer and lane scrolling.
// Every output registered, updating one cycle after its triggering input; inputs are never stalled.
module frogger_game_ctrl
  import frogger_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  frogger_game_ctrl_if.slave  bus
);

  localparam int          HIT_W    = $clog2(HIT_FRAMES + 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_FRAMES - 1);
  localparam logic [2:0]  GOAL_ROW = 3'(NUM_LANES + 1);
  localparam logic [9:0]  STEP     = 10'(FROG_STEP);
  localparam logic [9:0]  COL_MAX  = 10'(SCREEN_W - FROG_STEP);
  localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);

  game_state_e        state_q, state_d;
  logic [9:0]         col_q, col_d;
  logic [2:0]         row_q, row_d;
  logic [1:0]         lives_q, lives_d;
  logic [7:0]         score_q, score_d;
  logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               lane_clr;
  logic               lane_adv;
  logic [NUM_LANES*10-1:0] lane_off_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= FROG_START_COL;
      row_q     <= 3'd0;
      lives_q   <= 2'd0;
      score_q   <= 8'd0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    lives_d   = lives_q;
    score_d   = score_q;
    hit_cnt_d = hit_cnt_q;
    lane_clr  = 1'b0;
    lane_adv  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.btn_start) begin
          state_d  = S_PLAY;
          lives_d  = LIVES_INIT;
          score_d  = 8'd0;
          lane_clr = 1'b1;
          col_d    = FROG_START_COL;
          row_d    = 3'd0;
        end
      end

      S_PLAY: begin
        if (bus.frame_tick && bus.collision) begin
          // A hit swallows any move pressed in the same cycle.
          state_d   = S_HIT;
          lives_d   = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          hit_cnt_d = '0;
        end else begin
          lane_adv = bus.frame_tick;
          if (bus.btn_up) begin
            if (row_q == GOAL_ROW - 3'd1) begin
              score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              row_d   = 3'd0;
              col_d   = FROG_START_COL;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else if (bus.btn_down) begin
            if (row_q != 3'd0) row_d = row_q - 3'd1;
          end else if (bus.btn_left) begin
            if (col_q >= STEP) col_d = col_q - STEP;
          end else if (bus.btn_right) begin
            if (col_q <= COL_MAX - STEP) col_d = col_q + STEP;
          end
        end
      end

      S_HIT: begin
        if (bus.frame_tick) begin
          if (hit_cnt_q == HIT_LAST) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d = S_PLAY;
              col_d   = FROG_START_COL;
              row_d   = 3'd0;
            end
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
      end

      S_OVER: begin
        if (bus.btn_start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    frogger_lane_mover u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (lane_clr),
      .adv   (lane_adv),
      .speed (LANE_SPEED[i]),
      .dir   (LANE_DIR[i]),
      .off   (lane_off_w[10*i +: 10])
    );
  end

  assign bus.lane_off   = lane_off_w;
  assign bus.frog_col   = col_q;
  assign bus.frog_row   = row_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.game_state = state_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Self-checking bench for frogger_game_ctrl: directed scenarios plus random play against a rule model.
module tb_frogger_game_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  frogger_game_ctrl_if bus();
  frogger_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Game model in plain integers
  int m_state, m_col, m_row, m_lives, m_score, m_hit;
  int m_off [5];
  int speed [5] = '{1, 2, 3, 2, 4};
  bit go_left [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  localparam logic [75:0] RESET_VEC = {50'd0, 10'd320, 3'd0, 2'd0, 8'd0, 3'd0};

  task automatic model(input bit r, ft, st, up, dn, lf, rt, co);
    if (r) begin
      m_state = 0; m_col = 320; m_row = 0; m_lives = 0; m_score = 0; m_hit = 0;
      for (int i = 0; i < 5; i++) m_off[i] = 0;
      return;
    end
    case (m_state)
      0: if (st) begin
        m_state = 1; m_lives = 3; m_score = 0; m_col = 320; m_row = 0;
        for (int i = 0; i < 5; i++) m_off[i] = 0;
      end
      1: if (ft && co) begin
        m_state = 2; m_hit = 0;
        if (m_lives > 0) m_lives--;
      end else begin
        if (ft)
          for (int i = 0; i < 5; i++)
            m_off[i] = go_left[i] ? (m_off[i] + 640 - speed[i]) % 640 : (m_off[i] + speed[i]) % 640;
        if (up) begin
          m_row++;
          if (m_row == 6) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_row = 0; m_col = 320;
          end
        end else if (dn) begin
          if (m_row > 0) m_row--;
        end else if (lf) begin
          if (m_col - 16 >= 0) m_col -= 16;
        end else if (rt) begin
          if (m_col + 16 <= 624) m_col += 16;
        end
      end
      2: if (ft) begin
        m_hit++;
        if (m_hit == 60) begin
          if (m_lives == 0) m_state = 3;
          else begin m_state = 1; m_col = 320; m_row = 0; end
        end
      end
      3: if (st) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [75:0] exp_vec();
    logic [49:0] lo;
    for (int i = 0; i < 5; i++) lo[10*i +: 10] = 10'(m_off[i]);
    return {lo, 10'(m_col), 3'(m_row), 2'(m_lives), 8'(m_score), 3'(m_state)};
  endfunction

  function automatic logic [75:0] dut_vec();
    return {bus.lane_off, bus.frog_col, bus.frog_row, bus.lives, bus.score, bus.game_state};
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input bit r, ft, st, up, dn, lf, rt, co);
    rst = r; bus.frame_tick = ft; bus.btn_start = st; bus.btn_up = up;
    bus.btn_down = dn; bus.btn_left = lf; bus.btn_right = rt; bus.collision = co;
    model(r, ft, st, up, dn, lf, rt, co);
    @(posedge clk);
    #1;
    rst = 0; bus.frame_tick = 0; bus.btn_start = 0; bus.btn_up = 0;
    bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0; bus.collision = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++; $display("FAIL reset_values: got %h want %h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_start();
    step(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.game_state, bus.lives, bus.score, bus.frog_row, bus.frog_col} !==
        {3'd1, 2'd3, 8'd0, 3'd0, 10'd320}) begin
      errors++; $display("FAIL start: got st=%0d lives=%0d score=%0d row=%0d col=%0d",
                         bus.game_state, bus.lives, bus.score, bus.frog_row, bus.frog_col);
    end
  endtask

  task automatic test_lanes();
    for (int k = 1; k <= 640; k++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lanes_tick%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (k == 1) begin
        checks++;
        if (bus.lane_off[19:10] !== 10'd638) begin
          errors++; $display("FAIL lane1_first_tick: got %0d want 638", bus.lane_off[19:10]);
        end
      end
      if (k == 159 || k == 160) begin
        checks++;
        if (bus.lane_off[49:40] !== ((k == 159) ? 10'd636 : 10'd0)) begin
          errors++; $display("FAIL lane4_wrap_tick%0d: got %0d want %0d", k, bus.lane_off[49:40],
                             (k == 159) ? 636 : 0);
        end
      end
    end
    checks++;
    if (bus.lane_off[9:0] !== 10'd0) begin
      errors++; $display("FAIL lane0_full_cycle: got %0d want 0", bus.lane_off[9:0]);
    end
  endtask

  task automatic test_left_edge();
    for (int k = 1; k <= 21; k++) begin
      step(0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (bus.frog_col !== ((k >= 20) ? 10'd0 : 10'(320 - 16 * k))) begin
        errors++; $display("FAIL left_pulse%0d: got col %0d want %0d", k, bus.frog_col,
                           (k >= 20) ? 0 : 320 - 16 * k);
      end
    end
    step(0, 0, 0, 1, 0, 1, 0, 0);
    checks++;
    if ({bus.frog_row, bus.frog_col} !== {3'd1, 10'd0}) begin
      errors++; $display("FAIL up_left_priority: got row=%0d col=%0d want row=1 col=0",
                         bus.frog_row, bus.frog_col);
    end
  endtask

  task automatic test_goal();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (k < 6 && bus.frog_row !== 3'(k)) begin
        errors++; $display("FAIL goal_row%0d: got %0d want %0d", k, bus.frog_row, k);
      end else if (k == 6 && {bus.frog_row, bus.frog_col, bus.score} !== {3'd0, 10'd320, 8'd1}) begin
        errors++; $display("FAIL goal_cross: got row=%0d col=%0d score=%0d want 0/320/1",
                           bus.frog_row, bus.frog_col, bus.score);
      end
    end
    for (int n = 0; n < 255; n++) begin
      for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0, 0, 0, 0);
      if (n == 253 || n == 254) begin
        checks++;
        if (bus.score !== 8'd255 || dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL score_sat_%0d: got score %0d want 255", n, bus.score);
        end
      end
    end
  endtask

  task automatic test_hit();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int h = 1; h <= 3; h++) begin
      step(0, 1, 0, 1, 0, 0, 0, 1);
      checks++;
      if ({bus.game_state, bus.lives} !== {3'd2, 2'(3 - h)}) begin
        errors++; $display("FAIL hit%0d_enter: got st=%0d lives=%0d want 2/%0d", h,
                           bus.game_state, bus.lives, 3 - h);
      end
      for (int t = 1; t <= 60; t++) begin
        step(0, 1, 0, (t % 2 == 0), 0, 0, 1, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL hit%0d_tick%0d: got %h want %h", h, t, dut_vec(), exp_vec());
        end
      end
      checks++;
      if (bus.lane_off[9:0] !== 10'd3) begin
        errors++; $display("FAIL hit%0d_lanes_frozen: got %0d want 3", h, bus.lane_off[9:0]);
      end
      checks++;
      if (h < 3 && {bus.game_state, bus.frog_row, bus.frog_col} !== {3'd1, 3'd0, 10'd320}) begin
        errors++; $display("FAIL hit%0d_respawn: got st=%0d row=%0d col=%0d", h,
                           bus.game_state, bus.frog_row, bus.frog_col);
      end else if (h == 3 && bus.game_state !== 3'd3) begin
        errors++; $display("FAIL game_over: got st=%0d want 3", bus.game_state);
      end
    end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.game_state, bus.lives} !== {3'd0, 2'd0}) begin
      errors++; $display("FAIL over_to_idle: got st=%0d lives=%0d want 0/0", bus.game_state, bus.lives);
    end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.game_state, bus.lives} !== {3'd1, 2'd3}) begin
      errors++; $display("FAIL restart: got st=%0d lives=%0d want 1/3", bus.game_state, bus.lives);
    end
  endtask

  task automatic test_reset_mid_hit();
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 1);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++; $display("FAIL reset_mid_hit: got %h want %h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_random();
    bit r, ft, st, up, dn, lf, rt, co;
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      r  = ($urandom_range(0, 799) == 0);
      ft = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 29) == 0);
      up = ($urandom_range(0, 4) == 0);
      dn = ($urandom_range(0, 9) == 0);
      lf = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 3) == 0);
      co = ($urandom_range(0, 7) == 0);
      step(r, ft, st, up, dn, lf, rt, co);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_tick = 0; bus.btn_start = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.btn_left = 0; bus.btn_right = 0; bus.collision = 0;
    test_reset();
    test_start();
    test_lanes();
    test_left_edge();
    test_goal();
    test_hit();
    test_reset_mid_hit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
